// File: rtl/sim_host_pkg.sv
// Shared types and default constants for the simulation host monitor.
package sim_host_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_e;

  // Entry 0 sits in the LSBs.
  localparam logic [95:0] TOHOST_ADDR_DEFAULT  = {32'h8011fffc, 32'h80003000, 32'h80001000};
  localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h9a100000;
  localparam logic [31:0] PASS_CODE            = 32'd1;

endpackage

// File: rtl/sim_host_con_fifo.sv
// Console byte FIFO: registered storage, head visible the cycle after push.
module sim_host_con_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         r_overflow;
  logic         w_pop;
  logic         w_push;

  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop on an empty FIFO is meaningless; a push when full only fits if the head leaves.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  // Head byte forced to zero while empty so stale storage never leaks out.
  assign data_o     = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign overflow_o = r_overflow;

  // Storage array: written on accepted pushes, contents are irrelevant once pointers reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
  end

  // Pointers and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (push_i && full_o && !w_pop) r_overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/sim_host_monitor.sv
// Snoops the core data bus for tohost verdict writes and console bytes.
module sim_host_monitor
  import sim_host_pkg::*;
#(
  parameter int                       NUM_TOHOST   = 3,
  parameter logic [NUM_TOHOST*32-1:0] TOHOST_ADDRS = TOHOST_ADDR_DEFAULT,
  parameter logic [31:0]              CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT,
  parameter int                       CON_DEPTH    = 16,
  parameter int                       CYC_W        = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_req_i,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  input  logic [CYC_W-1:0] max_cycles_i,
  output logic             con_valid_o,
  output logic [7:0]       con_data_o,
  input  logic             con_ready_i,
  output logic             con_overflow_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [30:0]      fail_code_o,
  output logic [CYC_W-1:0] cycle_count_o
);

  mon_state_e       r_state;
  mon_state_e       w_state_nxt;
  logic             r_th_vld;
  logic [31:0]      r_th_data;
  logic [30:0]      r_fail_code;
  logic [CYC_W-1:0] r_cnt;
  logic [CYC_W-1:0] w_cnt_nxt;
  logic             w_th_match;
  logic             w_th_hit;
  logic             w_con_hit;
  logic             w_con_empty;
  logic             w_con_full;
  logic             w_unused;

  // Duplicate entries simply OR together.
  always_comb begin
    w_th_match = 1'b0;
    for (int i = 0; i < NUM_TOHOST; i++) begin
      if (data_addr_i == TOHOST_ADDRS[i*32 +: 32]) w_th_match = 1'b1;
    end
  end

  assign w_th_hit  = data_req_i & data_we_i & w_th_match;
  assign w_con_hit = data_req_i & data_we_i & data_be_i[0] & (data_addr_i == CONSOLE_ADDR);
  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_unused  = ^{data_be_i[3:1], w_con_full};

  // Tohost capture stage: valid flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_th_vld <= 1'b0;
    else         r_th_vld <= w_th_hit;
  end

  // Tohost capture stage: payload, only meaningful alongside r_th_vld.
  always_ff @(posedge clk_i) begin
    if (w_th_hit) r_th_data <= data_wdata_i;
  end

  // State, failure code and saturating cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= RUN;
      r_fail_code <= '0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == RUN && w_state_nxt == FAIL) r_fail_code <= r_th_data[31:1];
    end
  end

  // Verdict decision; a tohost value beats a coincident timeout. The timeout
  // fires on the edge where the counter first exceeds the limit.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == RUN) begin
      if (r_th_vld && r_th_data == PASS_CODE)          w_state_nxt = PASS;
      else if (r_th_vld && r_th_data != '0)            w_state_nxt = FAIL;
      else if (max_cycles_i != '0 && w_cnt_nxt > max_cycles_i) w_state_nxt = TIMEOUT;
    end
  end

  assign done_o        = (r_state != RUN);
  assign pass_o        = (r_state == PASS);
  assign fail_o        = (r_state == FAIL) || (r_state == TIMEOUT);
  assign timeout_o     = (r_state == TIMEOUT);
  assign fail_code_o   = (r_state == FAIL) ? r_fail_code : '0;
  assign cycle_count_o = r_cnt;
  assign con_valid_o   = ~w_con_empty;

  sim_host_con_fifo #(
    .DEPTH (CON_DEPTH),
    .W     (8)
  ) u_con_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (w_con_hit),
    .data_i     (data_wdata_i[7:0]),
    .pop_i      (con_valid_o & con_ready_i),
    .data_o     (con_data_o),
    .full_o     (w_con_full),
    .empty_o    (w_con_empty),
    .overflow_o (con_overflow_o)
  );

endmodule

// File: tb/tb_sim_host_monitor.sv
// Directed and randomized checks of the host monitor against a queue-based model.
module tb_sim_host_monitor;

  localparam int          DEPTH = 16;
  localparam logic [31:0] CON_A = 32'h9a100000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic [63:0] max_c;
  logic        con_valid, con_ready, con_ovf;
  logic [7:0]  con_data;
  logic        done, pass, fail, tmo;
  logic [30:0] code;
  logic [63:0] cnt;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] th_addr [3];
  logic [7:0]  q [$];
  logic        exp_ovf;
  logic [63:0] exp_cnt;
  int          kind;
  logic        rdy, popped, acc;
  logic [7:0]  b;
  logic [31:0] v;
  int          idx;

  always #5 clk = ~clk;

  sim_host_monitor dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .data_req_i    (req),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_addr_i   (addr),
    .data_wdata_i  (wdata),
    .max_cycles_i  (max_c),
    .con_valid_o   (con_valid),
    .con_data_o    (con_data),
    .con_ready_i   (con_ready),
    .con_overflow_o(con_ovf),
    .done_o        (done),
    .pass_o        (pass),
    .fail_o        (fail),
    .timeout_o     (tmo),
    .fail_code_o   (code),
    .cycle_count_o (cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic do_reset(input logic [63:0] m);
    rst_n = 1'b0; idle_bus(); con_ready = 1'b0; max_c = m;
    step(); step();
    rst_n = 1'b1;
  endtask

  // One-cycle bus write; returns just after the capturing edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = e;
    step();
    idle_bus();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    th_addr[0] = 32'h80001000; th_addr[1] = 32'h80003000; th_addr[2] = 32'h8011fffc;

    // Reset state
    do_reset(64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_valid", 64'(con_valid), 64'd0);
    chk("rst_cnt", cnt, 64'd0);
    step(); step(); step();
    chk("cnt_3", cnt, 64'd3);

    // Pass verdict with two-cycle latency, then sticky against later writes
    repeat (6) step();
    wr(32'h80001000, 32'h1, 4'hF);
    chk("pass_lat1", 64'(pass), 64'd0);
    step();
    chk("pass_lat2", 64'(pass), 64'd1);
    chk("pass_done", 64'(done), 64'd1);
    chk("pass_fail", 64'(fail), 64'd0);
    chk("pass_code", 64'(code), 64'd0);
    wr(32'h80003000, 32'h7, 4'hF);
    step(); step();
    chk("pass_sticky", 64'(pass), 64'd1);
    chk("pass_sticky_fail", 64'(fail), 64'd0);

    // Zero is ignored; fail code is value>>1
    do_reset(64'd0);
    wr(32'h80003000, 32'h0, 4'hF);
    step(); step();
    chk("zero_ignored", 64'(done), 64'd0);
    wr(32'h8011fffc, 32'h2B, 4'h0);
    step();
    chk("fail_flag", 64'(fail), 64'd1);
    chk("fail_code", 64'(code), 64'd21);
    chk("fail_pass", 64'(pass), 64'd0);
    wr(32'h80003000, 32'h0, 4'hF);
    step();
    chk("fail_sticky", 64'(code), 64'd21);

    // Timeout at limit 50
    do_reset(64'd50);
    for (int i = 0; i < 200 && !tmo; i++) step();
    chk("tmo_seen", 64'(tmo), 64'd1);
    chk("tmo_cnt", cnt, 64'd51);
    chk("tmo_fail", 64'(fail), 64'd1);
    chk("tmo_done", 64'(done), 64'd1);
    chk("tmo_code", 64'(code), 64'd0);

    // Tohost pass arriving in the same cycle as the timeout wins
    do_reset(64'd50);
    for (int i = 0; i < 200 && cnt != 64'd49; i++) step();
    chk("tie_cnt49", cnt, 64'd49);
    wr(32'h80001000, 32'h1, 4'hF);
    step();
    chk("tie_pass", 64'(pass), 64'd1);
    chk("tie_tmo", 64'(tmo), 64'd0);
    chk("tie_fail", 64'(fail), 64'd0);
    chk("tie_cnt", cnt, 64'd51);

    // Console bytes with a ready consumer
    do_reset(64'd0);
    con_ready = 1'b1;
    wr(CON_A, 32'h48, 4'hF);
    chk("con_h_v", 64'(con_valid), 64'd1);
    chk("con_h_d", 64'(con_data), 64'h48);
    step();
    chk("con_h_pop", 64'(con_valid), 64'd0);
    wr(CON_A, 32'h69, 4'hF);
    chk("con_i_v", 64'(con_valid), 64'd1);
    chk("con_i_d", 64'(con_data), 64'h69);
    step();
    chk("con_i_pop", 64'(con_valid), 64'd0);
    wr(CON_A, 32'h55, 4'b0010);
    chk("con_be_nopush", 64'(con_valid), 64'd0);

    // Fill, overflow, drain in order
    con_ready = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      wr(CON_A, 32'(k), 4'hF);
      if (k == 16) chk("fill16_ovf", 64'(con_ovf), 64'd0);
    end
    chk("fill17_ovf", 64'(con_ovf), 64'd1);
    con_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk("drain_d", 64'(con_data), 64'(k));
      step();
    end
    chk("drain_empty", 64'(con_valid), 64'd0);

    // Push and pop together at full
    do_reset(64'd0);
    for (int k = 1; k <= 16; k++) wr(CON_A, 32'h20 + 32'(k), 4'hF);
    con_ready = 1'b1;
    wr(CON_A, 32'hAA, 4'hF);
    con_ready = 1'b0;
    chk("pp_full_ovf", 64'(con_ovf), 64'd0);
    con_ready = 1'b1;
    for (int k = 2; k <= 16; k++) begin
      chk("pp_drain", 64'(con_data), 64'h20 + 64'(k));
      step();
    end
    chk("pp_last", 64'(con_data), 64'hAA);
    step();
    chk("pp_empty", 64'(con_valid), 64'd0);

    // Asynchronous reset mid-stream
    do_reset(64'd0);
    for (int k = 0; k < 5; k++) wr(CON_A, 32'h30 + 32'(k), 4'hF);
    wr(32'h80001000, 32'h6, 4'hF);
    step(); step();
    chk("ar_pre_fail", 64'(fail), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(con_valid), 64'd0);
    chk("ar_data", 64'(con_data), 64'd0);
    chk("ar_fail", 64'(fail), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    chk("ar_code", 64'(code), 64'd0);
    chk("ar_cnt", cnt, 64'd0);
    step();
    rst_n = 1'b1;
    chk("ar_rel_valid", 64'(con_valid), 64'd0);
    step();
    chk("ar_cnt_restart", cnt, 64'd1);

    // Randomized tohost values at random monitored addresses
    for (int it = 0; it < 12; it++) begin
      do_reset(64'd0);
      idx = int'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       v = 32'h0;
        1:       v = 32'h1;
        default: v = $urandom | 32'h2;
      endcase
      wr(th_addr[idx], v, 4'(($urandom)));
      step();
      chk("rnd_done", 64'(done), 64'(v != 32'h0));
      chk("rnd_pass", 64'(pass), 64'(v == 32'h1));
      chk("rnd_fail", 64'(fail), 64'(v > 32'h1));
      chk("rnd_code", 64'(code), (v > 32'h1) ? 64'(v / 2) : 64'd0);
    end

    // Randomized console traffic against a queue model
    do_reset(64'd0);
    q.delete();
    exp_ovf = 1'b0;
    exp_cnt = 64'd0;
    for (int i = 0; i < 600; i++) begin
      kind = int'($urandom_range(0, 9));
      b    = 8'($urandom);
      rdy  = ($urandom_range(0, 99) < ((i < 300) ? 30 : 70));
      idle_bus();
      if (kind <= 7) begin
        req = 1'b1; we = 1'b1; wdata = {24'($urandom), b};
        be   = (kind == 6) ? 4'b1110 : 4'b0001 | 4'($urandom);
        addr = (kind == 7) ? CON_A + 32'd4 : CON_A;
      end
      con_ready = rdy;
      popped = (q.size() > 0) && rdy;
      acc    = 1'b0;
      if (kind <= 5) begin
        if (q.size() < DEPTH || popped) acc = 1'b1;
        else exp_ovf = 1'b1;
      end
      if (popped) void'(q.pop_front());
      if (acc) q.push_back(b);
      step();
      exp_cnt++;
      chk("r_valid", 64'(con_valid), 64'(q.size() > 0));
      chk("r_data", 64'(con_data), (q.size() > 0) ? 64'(q[0]) : 64'd0);
      chk("r_ovf", 64'(con_ovf), 64'(exp_ovf));
    end
    idle_bus();
    chk("r_cnt", cnt, exp_cnt);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sim_host_monitor.md
Name: sim_host_monitor

Overview:
Synthesizable, parametrised host-interface monitor for the zero-riscy simulation top. It snoops the core data bus for tohost writes at N configurable addresses and for console byte writes. It decodes a sticky PASS/FAIL/TIMEOUT verdict and buffers console characters in a FIFO drained by a valid/ready consumer. Benches, or an FPGA debug wrapper, read status ports instead of embedding checks in the bench.

Parameters:
NUM_TOHOST, 3, number of tohost addresses monitored (1..8)
TOHOST_ADDRS, {32'h8011fffc,32'h80003000,32'h80001000}, packed NUM_TOHOST x 32 address list; entry 0 in the LSBs
CONSOLE_ADDR, 32'h9a100000, console byte write address
CON_DEPTH, 16, console FIFO depth; power of two, >=2
CYC_W, 64, cycle counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
data_req_i  in  1  core data request
data_we_i  in  1  write enable
data_be_i  in  4  byte enables
data_addr_i  in  32  byte address
data_wdata_i  in  32  write data
max_cycles_i  in  CYC_W  timeout limit; 0 disables the timeout
con_valid_o  out  1  console FIFO not empty
con_data_o  out  8  FIFO head byte
con_ready_i  in  1  consumer pops the head byte when con_valid_o is high
con_overflow_o  out  1  sticky: a byte was dropped because the FIFO was full
done_o  out  1  verdict reached (sticky)
pass_o  out  1  tohost == 1 was seen
fail_o  out  1  nonzero tohost != 1 was seen, or timeout occurred
timeout_o  out  1  cycle limit exceeded
fail_code_o  out  31  tohost>>1 on failure; 0 on pass or timeout
cycle_count_o  out  CYC_W  cycles since reset release

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, FSM in RUN, counter 0.
- Hit definition: hit = data_req_i & data_we_i & address match. Byte enables are ignored for tohost hits. Console hits require data_be_i[0].
- Tohost pipeline: a tohost hit registers (valid, wdata) in cycle N. The FSM evaluates the registered value in cycle N+1, so verdict outputs are high from the edge ending cycle N+1 (2-cycle latency). A registered value of 0 is ignored.
- FSM states: RUN, PASS, FAIL, TIMEOUT. All three non-RUN states are terminal until reset.
  - RUN->PASS: registered tohost == 1.
  - RUN->FAIL: registered tohost nonzero and != 1; fail_code_o = value[31:1].
  - RUN->TIMEOUT: max_cycles_i != 0 and cycle_count_o > max_cycles_i. Sets timeout_o and fail_o.
  - If a tohost verdict and the timeout fire in the same cycle, the tohost verdict wins.
- Outputs: done_o = (state != RUN); outputs decode from the state register only.
- Cycle counter: increments every cycle after reset release and keeps counting after done_o. Saturates at all-ones; no wrap.
- Duplicate address entries are legal; they are OR-matched.
- Console FIFO: push = console hit, byte = data_wdata_i[7:0]. Pop = con_valid_o & con_ready_i. con_data_o is the registered head with zero combinational path from push, so a byte pushed in cycle N is visible with con_valid_o in cycle N+1.
- Simultaneous push and pop:
  - When full: allowed, no overflow.
  - When empty: the push is stored and the pop is ignored (con_valid_o was low).
- Push when full without a pop: the byte is dropped and con_overflow_o is set sticky.
- Pointers are log2(CON_DEPTH)+1 bits wide and wrap naturally. Occupancy is exactly CON_DEPTH at full.
- The console keeps accepting bytes after done_o.
- A reset asserted mid-operation clears the FIFO contents, verdict and counter immediately.

Decomposition:
- Package sim_host_pkg holds:
  - the state enum (RUN, PASS, FAIL, TIMEOUT) as typedef mon_state_e;
  - the default address constants TOHOST_ADDR_DEFAULT and CONSOLE_ADDR_DEFAULT;
  - the PASS_CODE = 32'd1 constant.
- One sub-module, sim_host_con_fifo: a parametrised sync FIFO with push/pop, full/empty and overflow_o. The top holds address decode, the tohost pipeline register, the FSM and the counter.

Test Plan:
1. Reset, then write 32'h1 to 32'h80001000 at cycle 10 -> pass_o/done_o high at cycle 12, fail_o=0, fail_code_o=0; a later write of 32'h7 leaves PASS unchanged.
2. Write 32'h2B to 32'h8011fffc -> fail_o=1, fail_code_o=21, pass_o=0. Write 32'h0 to 32'h80003000 -> no state change.
3. max_cycles_i=50, no writes -> timeout_o=fail_o=done_o=1 when cycle_count_o=51. Repeat with tohost=1 landing the same cycle -> PASS, timeout_o=0.
4. Write "H","i" (32'h48, 32'h69) to 32'h9a100000 with con_ready_i=1 -> con_valid_o pulses one cycle each, bytes 8'h48 then 8'h69 in order. Write to 32'h9a100000 with data_be_i=4'b0010 -> no push.
5. con_ready_i=0, 17 console writes with CON_DEPTH=16 -> FIFO full after 16, con_overflow_o=1 after the 17th. Drain -> 16 bytes are bytes 1..16. Then simultaneous push+pop at full -> count stays 16, no new overflow.
6. Assert rst_ni low mid-stream with 5 bytes buffered and a FAIL verdict -> all outputs 0 asynchronously, FIFO empty after release, counter restarts from 0.
